lc2k_multicycle_control: RTL and testbench

- Multicycle control FSM for the LC2K CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath control line.
- Drives CONTROL_WRITE_REG, the select of the downstream write-register mux: 1 selects destReg, 0 selects regB.
- Talks to a single unified memory through a req/ready handshake, counts retired instructions, and latches a sticky halted flag.

---
 rtl/lc2k_multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_lc2k_multicycle_control.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_multicycle_control.sv
// Multicycle control FSM for the LC2K CPU: sequences fetch/decode/execute/memory/writeback,
// drives every datapath control line, counts retired instructions and latches a sticky halt flag.
module lc2k_multicycle_control #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2:0]             opcode,
   input  logic                   alu_eq,
   input  logic                   mem_ready,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic                   mem_addr_sel,
   output logic                   ir_load,
   output logic                   pc_load,
   output logic [1:0]             pc_src,
   output logic [1:0]             alu_op,
   output logic                   alu_src_b,
   output logic                   reg_write,
   output logic                   CONTROL_WRITE_REG,
   output logic [1:0]             wb_src,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] instr_count,
   output logic [3:0]             state_out
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_WB_R   = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_WB_M   = 4'd6,
      S_MEM_WR = 4'd7,
      S_BRANCH = 4'd8,
      S_JALR   = 4'd9,
      S_HALT   = 4'd10
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_JALR = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   halted_q;
   logic                   retire;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (retire) count_q <= count_q + COUNT_WIDTH'(1'b1);
         if (state_d == S_HALT) halted_q <= 1'b1;
      end
   end

   // NOTE: every output gets a default first, so no latch can be inferred.
   always_comb begin
      state_d           = state_q;
      retire            = 1'b0;
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      mem_addr_sel      = 1'b0;
      ir_load           = 1'b0;
      pc_load           = 1'b0;
      pc_src            = 2'd0;
      alu_op            = 2'd0;
      alu_src_b         = 1'b0;
      reg_write         = 1'b0;
      CONTROL_WRITE_REG = 1'b0;
      wb_src            = 2'd0;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            pc_load = 1'b1;
            case (opcode)
               OP_ADD, OP_NOR: state_d = S_EXEC;
               OP_LW, OP_SW:   state_d = S_ADDR;
               OP_BEQ:         state_d = S_BRANCH;
               OP_JALR:        state_d = S_JALR;
               OP_HALT: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
               default: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            endcase
         end
         S_EXEC: begin
            alu_op  = (opcode == OP_NOR) ? 2'd1 : 2'd0;
            state_d = S_WB_R;
         end
         S_WB_R: begin
            reg_write         = 1'b1;
            CONTROL_WRITE_REG = 1'b1;
            state_d           = S_FETCH;
            retire            = 1'b1;
         end
         S_ADDR: begin
            alu_src_b = 1'b1;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            alu_src_b    = 1'b1;
            if (mem_ready) state_d = S_WB_M;
         end
         S_WB_M: begin
            reg_write = 1'b1;
            wb_src    = 2'd1;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_MEM_WR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            alu_src_b    = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_BRANCH: begin
            alu_op  = 2'd2;
            pc_load = alu_eq;
            pc_src  = 2'd1;
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_JALR: begin
            // Link value is the PC already incremented in DECODE; regA is read before the edge.
            reg_write = 1'b1;
            wb_src    = 2'd2;
            pc_load   = 1'b1;
            pc_src    = 2'd2;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         mem_req           = 1'b0;
         mem_we            = 1'b0;
         mem_addr_sel      = 1'b0;
         ir_load           = 1'b0;
         pc_load           = 1'b0;
         pc_src            = 2'd0;
         alu_op            = 2'd0;
         alu_src_b         = 1'b0;
         reg_write         = 1'b0;
         CONTROL_WRITE_REG = 1'b0;
         wb_src            = 2'd0;
      end
   end

   assign halted      = halted_q;
   assign instr_count = count_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_lc2k_multicycle_control.sv
// Directed-vector bench for lc2k_multicycle_control: per-cycle state and control-line checks
// against hand-computed constants, plus retirement count, halt and reset behaviour.
module tb_lc2k_multicycle_control;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC   = 4'd2;
   localparam logic [3:0] S_WB_R   = 4'd3;
   localparam logic [3:0] S_ADDR   = 4'd4;
   localparam logic [3:0] S_MEM_RD = 4'd5;
   localparam logic [3:0] S_WB_M   = 4'd6;
   localparam logic [3:0] S_MEM_WR = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JALR   = 4'd9;
   localparam logic [3:0] S_HALT   = 4'd10;

   // ctrl = {req, we, addr_sel, ir_load, pc_load, pc_src, alu_op, alu_src_b, reg_write, cwr, wb_src}
   localparam logic [13:0] C_ZERO       = 14'b0_0_0_0_0_00_00_0_0_0_00;
   localparam logic [13:0] C_FETCH      = 14'b1_0_0_1_0_00_00_0_0_0_00;
   localparam logic [13:0] C_FETCH_WAIT = 14'b1_0_0_0_0_00_00_0_0_0_00;
   localparam logic [13:0] C_DECODE     = 14'b0_0_0_0_1_00_00_0_0_0_00;
   localparam logic [13:0] C_EXEC_NOR   = 14'b0_0_0_0_0_00_01_0_0_0_00;
   localparam logic [13:0] C_WB_R       = 14'b0_0_0_0_0_00_00_0_1_1_00;
   localparam logic [13:0] C_ADDR       = 14'b0_0_0_0_0_00_00_1_0_0_00;
   localparam logic [13:0] C_MEM_RD     = 14'b1_0_1_0_0_00_00_1_0_0_00;
   localparam logic [13:0] C_WB_M       = 14'b0_0_0_0_0_00_00_0_1_0_01;
   localparam logic [13:0] C_MEM_WR     = 14'b1_1_1_0_0_00_00_1_0_0_00;
   localparam logic [13:0] C_BR_TAKEN   = 14'b0_0_0_0_1_01_10_0_0_0_00;
   localparam logic [13:0] C_BR_NOT     = 14'b0_0_0_0_0_01_10_0_0_0_00;
   localparam logic [13:0] C_JALR       = 14'b0_0_0_0_1_10_00_0_1_0_10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opcode = 3'd0;
   logic       alu_eq = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
   logic [1:0] pc_src, alu_op, wb_src;
   logic       alu_src_b, reg_write, CONTROL_WRITE_REG, halted;
   logic [2:0] instr_count;
   logic [3:0] state_out;
   logic [13:0] ctrl;

   int checks = 0;
   int errors = 0;

   lc2k_multicycle_control #(.COUNT_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_eq(alu_eq), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
      .pc_load(pc_load), .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
      .reg_write(reg_write), .CONTROL_WRITE_REG(CONTROL_WRITE_REG), .wb_src(wb_src),
      .halted(halted), .instr_count(instr_count), .state_out(state_out)
   );

   assign ctrl = {mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_src, alu_op,
                  alu_src_b, reg_write, CONTROL_WRITE_REG, wb_src};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; opcode = 3'd7; alu_eq = 1'b0; mem_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 3'd0; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (state_out !== S_FETCH || ctrl !== C_ZERO || instr_count !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset %0d: got state %0d ctrl %b cnt %0d halted %b, want 0 %b 0 0",
                     i, state_out, ctrl, instr_count, halted, C_ZERO);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_add();
      logic [3:0]  st [4];
      logic [13:0] cv [4];
      st = '{S_FETCH, S_DECODE, S_EXEC, S_WB_R};
      cv = '{C_FETCH, C_DECODE, C_ZERO, C_WB_R};
      do_reset();
      opcode = 3'd0; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (state_out !== st[i] || ctrl !== cv[i]) begin
            errors++;
            $display("FAIL add cyc %0d: got state %0d ctrl %b, want state %0d ctrl %b",
                     i, state_out, ctrl, st[i], cv[i]);
         end
         tick();
      end
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd1) begin
         errors++;
         $display("FAIL add retire: got state %0d cnt %0d, want 0 1", state_out, instr_count);
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0]  st [8];
      logic [13:0] cv [8];
      logic        rd [8];
      st = '{S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_WB_M};
      cv = '{C_FETCH, C_DECODE, C_ADDR, C_MEM_RD, C_MEM_RD, C_MEM_RD, C_MEM_RD, C_WB_M};
      rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      opcode = 3'd2;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rd[i];
         #1;
         checks++;
         if (state_out !== st[i] || ctrl !== cv[i]) begin
            errors++;
            $display("FAIL lw cyc %0d: got state %0d ctrl %b, want state %0d ctrl %b",
                     i, state_out, ctrl, st[i], cv[i]);
         end
         tick();
      end
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd1) begin
         errors++;
         $display("FAIL lw retire: got state %0d cnt %0d, want 0 1", state_out, instr_count);
      end
   endtask

   task automatic test_branch();
      logic [3:0]  st [6];
      logic [13:0] cv [6];
      logic        eq [6];
      st = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH};
      cv = '{C_FETCH, C_DECODE, C_BR_TAKEN, C_FETCH, C_DECODE, C_BR_NOT};
      eq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      opcode = 3'd4; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         alu_eq = eq[i];
         #1;
         checks++;
         if (state_out !== st[i] || ctrl !== cv[i]) begin
            errors++;
            $display("FAIL beq cyc %0d: got state %0d ctrl %b, want state %0d ctrl %b",
                     i, state_out, ctrl, st[i], cv[i]);
         end
         tick();
      end
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd2) begin
         errors++;
         $display("FAIL beq retire: got state %0d cnt %0d, want 0 2", state_out, instr_count);
      end
   endtask

   task automatic test_jalr();
      logic [3:0]  st [3];
      logic [13:0] cv [3];
      st = '{S_FETCH, S_DECODE, S_JALR};
      cv = '{C_FETCH, C_DECODE, C_JALR};
      do_reset();
      opcode = 3'd5; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (state_out !== st[i] || ctrl !== cv[i]) begin
            errors++;
            $display("FAIL jalr cyc %0d: got state %0d ctrl %b, want state %0d ctrl %b",
                     i, state_out, ctrl, st[i], cv[i]);
         end
         tick();
      end
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd1) begin
         errors++;
         $display("FAIL jalr retire: got state %0d cnt %0d, want 0 1", state_out, instr_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  st [9];
      logic [13:0] cv [9];
      logic [2:0]  op [9];
      logic        rd [9];
      st = '{S_FETCH, S_DECODE, S_EXEC, S_WB_R, S_FETCH, S_DECODE, S_ADDR, S_MEM_WR, S_MEM_WR};
      cv = '{C_FETCH, C_DECODE, C_EXEC_NOR, C_WB_R, C_FETCH, C_DECODE, C_ADDR, C_MEM_WR, C_MEM_WR};
      op = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
      rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         opcode = op[i]; mem_ready = rd[i];
         #1;
         checks++;
         if (state_out !== st[i] || ctrl !== cv[i]) begin
            errors++;
            $display("FAIL b2b cyc %0d: got state %0d ctrl %b, want state %0d ctrl %b",
                     i, state_out, ctrl, st[i], cv[i]);
         end
         tick();
      end
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd2) begin
         errors++;
         $display("FAIL b2b retire: got state %0d cnt %0d, want 0 2", state_out, instr_count);
      end
   endtask

   task automatic test_halt();
      do_reset();
      opcode = 3'd7;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state_out !== S_FETCH || ctrl !== C_FETCH_WAIT) begin
         errors++;
         $display("FAIL fetch stall: got state %0d ctrl %b, want 0 %b", state_out, ctrl, C_FETCH_WAIT);
      end
      tick();
      mem_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         tick();
      end
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd5) begin
         errors++;
         $display("FAIL noop x5: got state %0d cnt %0d, want 0 5", state_out, instr_count);
      end
      opcode = 3'd6;
      tick();
      #1;
      checks++;
      if (state_out !== S_DECODE || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt decode: got state %0d halted %b, want 1 0", state_out, halted);
      end
      tick();
      checks++;
      if (state_out !== S_HALT || halted !== 1'b1 || instr_count !== 3'd6) begin
         errors++;
         $display("FAIL halt entry: got state %0d halted %b cnt %0d, want 10 1 6",
                  state_out, halted, instr_count);
      end
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         opcode = 3'(i);
         #1;
         checks++;
         if (state_out !== S_HALT || ctrl !== C_ZERO || halted !== 1'b1 || instr_count !== 3'd6) begin
            errors++;
            $display("FAIL halt hold %0d: got state %0d ctrl %b halted %b cnt %0d, want 10 %b 1 6",
                     i, state_out, ctrl, halted, instr_count, C_ZERO);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      checks++;
      if (halted !== 1'b0 || instr_count !== 3'd0) begin
         errors++;
         $display("FAIL halt cleared: got halted %b cnt %0d, want 0 0", halted, instr_count);
      end
      opcode = 3'd3; mem_ready = 1'b1;
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state_out !== S_MEM_WR || ctrl !== C_MEM_WR) begin
         errors++;
         $display("FAIL sw wait: got state %0d ctrl %b, want 7 %b", state_out, ctrl, C_MEM_WR);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_ZERO || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset gate: got ctrl %b mem_req %b, want %b 0", ctrl, mem_req, C_ZERO);
      end
      tick();
      checks++;
      if (state_out !== S_FETCH || instr_count !== 3'd0 || mem_we !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset abandon: got state %0d cnt %0d we %b req %b, want 0 0 0 0",
                  state_out, instr_count, mem_we, mem_req);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (state_out !== S_FETCH || ctrl !== C_FETCH_WAIT) begin
         errors++;
         $display("FAIL post reset fetch: got state %0d ctrl %b, want 0 %b", state_out, ctrl, C_FETCH_WAIT);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      opcode = 3'd7; mem_ready = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         tick();
         tick();
         if (n == 7 || n == 8 || n == 9) begin
            checks++;
            if (instr_count !== 3'(n)) begin
               errors++;
               $display("FAIL wrap after %0d: got cnt %0d, want %0d", n, instr_count, 3'(n));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_jalr();
      test_back_to_back();
      test_halt();
      test_reset_mid_write();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
